// File: rtl/tx_framer.sv
// TX channel framing stage: wraps AXI4-Stream frames in SCP/ECP, pads the last beat
// and injects periodic clock-compensation runs. Define TX_FRAMER_STATS_EN for frame/abort counters.
module tx_framer #(
  parameter int unsigned AXI_DATA_SIZE = 32,
  parameter int unsigned CC_PERIOD     = 5000,
  parameter int unsigned CC_LEN        = 6,
  parameter logic [7:0]  PAD_CHAR      = 8'h9C
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       channel_up,
  input  logic [AXI_DATA_SIZE-1:0]   s_axis_tdata,
  input  logic [AXI_DATA_SIZE/8-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [2:0]                 ordered_sets,
  output logic [AXI_DATA_SIZE-1:0]   data_out
`ifdef TX_FRAMER_STATS_EN
  ,
  output logic [15:0]                frame_cnt,
  output logic [7:0]                 abort_cnt
`endif
);

  localparam int unsigned KEEP_W = AXI_DATA_SIZE / 8;
  localparam int unsigned CNT_W  = $clog2(CC_PERIOD);
  localparam int unsigned LEFT_W = $clog2(CC_LEN + 1);

  // Ordered-set command encoding shared with lane_controller
  localparam logic [2:0] OS_I   = 3'd0;
  localparam logic [2:0] OS_SCP = 3'd1;
  localparam logic [2:0] OS_ECP = 3'd2;
  localparam logic [2:0] OS_D   = 3'd3;
  localparam logic [2:0] OS_CC  = 3'd4;

  typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_DATA, ST_EOF, ST_CC} state_e;

  state_e                   state;
  state_e                   ret_state;
  logic [CNT_W-1:0]         cc_cnt;
  logic                     cc_pending;
  logic [LEFT_W-1:0]        cc_left;
  logic [AXI_DATA_SIZE-1:0] padded;
  logic                     cc_req;
  logic                     beat;

  // Only the last beat of a frame may carry invalid bytes
  always_comb begin
    padded = s_axis_tdata;
    for (int i = 0; i < KEEP_W; i++) begin
      if (s_axis_tlast && !s_axis_tkeep[i]) padded[8*i +: 8] = PAD_CHAR;
    end
  end

  assign s_axis_tready = channel_up && (state == ST_DATA) && !cc_pending;
  assign beat          = s_axis_tvalid && s_axis_tready;
  assign cc_req        = (cc_cnt == CNT_W'(CC_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst || !channel_up) begin
      state        <= ST_IDLE;
      ret_state    <= ST_IDLE;
      ordered_sets <= OS_I;
      data_out     <= '0;
      cc_cnt       <= '0;
      cc_pending   <= 1'b0;
      cc_left      <= '0;
    end else begin
      cc_cnt       <= cc_req ? '0 : cc_cnt + CNT_W'(1);
      ordered_sets <= OS_I;
      data_out     <= '0;
      case (state)
        ST_IDLE: begin
          if (cc_pending) begin
            state     <= ST_CC;
            ret_state <= ST_IDLE;
            cc_left   <= LEFT_W'(CC_LEN);
          end else if (s_axis_tvalid) begin
            state <= ST_SOF;
          end
        end
        ST_SOF: begin
          ordered_sets <= OS_SCP;
          state        <= ST_DATA;
        end
        ST_DATA: begin
          if (cc_pending) begin
            state     <= ST_CC;
            ret_state <= ST_DATA;
            cc_left   <= LEFT_W'(CC_LEN);
          end else if (beat) begin
            ordered_sets <= OS_D;
            data_out     <= padded;
            if (s_axis_tlast) state <= ST_EOF;
          end
        end
        ST_EOF: begin
          ordered_sets <= OS_ECP;
          if (cc_pending) begin
            state     <= ST_CC;
            ret_state <= ST_IDLE;
            cc_left   <= LEFT_W'(CC_LEN);
          end else if (s_axis_tvalid) begin
            state <= ST_SOF;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CC: begin
          ordered_sets <= OS_CC;
          if (cc_left <= LEFT_W'(1)) begin
            state      <= ret_state;
            cc_pending <= 1'b0;
          end else begin
            cc_left <= cc_left - LEFT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A request while one is already pending simply merges into it
      if (cc_req) cc_pending <= 1'b1;
    end
  end

`ifdef TX_FRAMER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      if (channel_up && state == ST_EOF) frame_cnt <= frame_cnt + 16'd1;
      if (!channel_up && (state == ST_SOF || state == ST_DATA || state == ST_EOF) &&
          abort_cnt != 8'hFF) begin
        abort_cnt <= abort_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tx_framer.sv
// Scoreboard bench for tx_framer: expected SCP/D/ECP symbols are queued as beats are
// handed over and checked as they appear; CC runs, gaps and aborts are checked alongside.
module tb_tx_framer;

  localparam int unsigned W         = 32;
  localparam int unsigned CC_PERIOD = 20;
  localparam int unsigned CC_LEN    = 6;

  localparam logic [2:0] OS_I   = 3'd0;
  localparam logic [2:0] OS_SCP = 3'd1;
  localparam logic [2:0] OS_ECP = 3'd2;
  localparam logic [2:0] OS_D   = 3'd3;
  localparam logic [2:0] OS_CC  = 3'd4;

  logic         clk = 1'b0;
  logic         rst;
  logic         channel_up;
  logic [W-1:0] tdata;
  logic [3:0]   tkeep;
  logic         tvalid;
  logic         tlast;
  logic         tready;
  logic [2:0]   ordered_sets;
  logic [W-1:0] data_out;
`ifdef TX_FRAMER_STATS_EN
  logic [15:0]  frame_cnt;
  logic [7:0]   abort_cnt;
`endif

  always #5 clk = ~clk;

  tx_framer #(
    .AXI_DATA_SIZE(W),
    .CC_PERIOD    (CC_PERIOD),
    .CC_LEN       (CC_LEN),
    .PAD_CHAR     (8'h9C)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .channel_up   (channel_up),
    .s_axis_tdata (tdata),
    .s_axis_tkeep (tkeep),
    .s_axis_tvalid(tvalid),
    .s_axis_tlast (tlast),
    .s_axis_tready(tready),
    .ordered_sets (ordered_sets),
    .data_out     (data_out)
`ifdef TX_FRAMER_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .abort_cnt    (abort_cnt)
`endif
  );

  typedef struct {
    logic [2:0]   sym;
    logic [W-1:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         tests_run    = 0;
  int         tests_failed = 0;
  int         ecp_cnt      = 0;
  int         b2b_cnt      = 0;
  int         tready_cnt   = 0;
  int         cc_runs      = 0;
  int         cc_run       = 0;
  int         i_run        = 0;
  int         max_gap      = 0;
  int         frames_sent  = 0;
  logic       seen_d       = 1'b0;
  logic       prev_tready  = 1'b0;
  logic [2:0] prev_sym     = 3'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] sym, input logic [W-1:0] data);
    exp_t e;
    e.sym  = sym;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until the DUT takes it; queue what it should emit
  task automatic send_beat(input logic [W-1:0] d, input logic [3:0] k, input logic l,
                           input logic [W-1:0] exp_d);
    logic done;
    done   = 1'b0;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tvalid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (tready) begin
        push_exp(OS_D, exp_d);
        if (l) begin
          push_exp(OS_ECP, '0);
          frames_sent++;
        end
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check_eq("beat_accepted", 32'(done), 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) step(1);
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    step(2);
  endtask

  // Output monitor: scoreboard, CC run length, CC backpressure, gap and adjacency tracking
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tready) tready_cnt++;
        if (ordered_sets != OS_D) check_eq("non_d_data_zero", data_out, 32'd0);
        if (ordered_sets == OS_SCP || ordered_sets == OS_D || ordered_sets == OS_ECP) begin
          if (exp_q.size() == 0) begin
            check_eq("sb_unexpected", 32'(ordered_sets), 32'(OS_I));
          end else begin
            mon_e = exp_q.pop_front();
            check_eq("sb_sym", 32'(ordered_sets), 32'(mon_e.sym));
            if (mon_e.sym == OS_D) check_eq("sb_data", data_out, mon_e.data);
          end
        end
        if (ordered_sets == OS_ECP) ecp_cnt++;
        if (prev_sym == OS_ECP && ordered_sets == OS_SCP) b2b_cnt++;
        if (ordered_sets == OS_CC) check_eq("cc_tready", 32'(prev_tready), 32'd0);
        if (!channel_up) begin
          cc_run = 0;
        end else if (ordered_sets == OS_CC) begin
          cc_run++;
        end else if (cc_run != 0) begin
          check_eq("cc_len", 32'(cc_run), 32'(CC_LEN));
          cc_runs++;
          cc_run = 0;
        end
        if (ordered_sets == OS_D) begin
          if (seen_d && i_run > max_gap) max_gap = i_run;
          seen_d = 1'b1;
          i_run  = 0;
        end else if (ordered_sets == OS_I) begin
          i_run++;
        end else begin
          seen_d = 1'b0;
          i_run  = 0;
        end
        prev_sym    = ordered_sets;
        prev_tready = tready;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int tc0;
    int b0;
    int c0;
    int e0;
    logic [W-1:0] d;

    rst        = 1'b1;
    channel_up = 1'b1;
    tvalid     = 1'b1;
    tdata      = '0;
    tkeep      = 4'hF;
    tlast      = 1'b0;
    step(3);
    @(negedge clk);
    check_eq("rst_ordered_sets", 32'(ordered_sets), 32'(OS_I));
    check_eq("rst_data_out", data_out, 32'd0);
    check_eq("rst_tready", 32'(tready), 32'd0);
    tvalid     = 1'b0;
    channel_up = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2);

    // First CC run after channel_up with nothing to send
    channel_up = 1'b1;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ordered_sets == OS_CC) break;
    end
    check_eq("cc_first_delay", 32'(k), 32'd22);
    step(10);

    // Single full beat; tready high for exactly one cycle
    tc0 = tready_cnt;
    push_exp(OS_SCP, '0);
    send_beat(32'hDEADBEEF, 4'hF, 1'b1, 32'hDEADBEEF);
    tvalid = 1'b0;
    drain("t2_drain");
    check_eq("t2_tready_cycles", 32'(tready_cnt - tc0), 32'd1);

    // Three beats: tkeep ignored on non-last beats, last beat padded
    push_exp(OS_SCP, '0);
    send_beat(32'hAABBCCDD, 4'h0, 1'b0, 32'hAABBCCDD);
    send_beat(32'h55667788, 4'h8, 1'b0, 32'h55667788);
    send_beat(32'h11223344, 4'hC, 1'b1, 32'h11229C9C);
    tvalid = 1'b0;
    drain("t3_drain");

    // Back-to-back frames with tvalid held; last one has all-zero tkeep
    b0 = b2b_cnt;
    for (int f = 0; f < 3; f++) begin
      push_exp(OS_SCP, '0);
      send_beat(32'hF0000000 | 32'(f), 4'hF, 1'b0, 32'hF0000000 | 32'(f));
      if (f == 2) send_beat(32'h0BADF00D, 4'h0, 1'b1, 32'h9C9C9C9C);
      else        send_beat(32'hE0000000 | 32'(f), 4'hF, 1'b1, 32'hE0000000 | 32'(f));
    end
    tvalid = 1'b0;
    drain("t4_drain");
    check_eq("t4_back_to_back", 32'(b2b_cnt - b0 >= 1), 32'd1);

    // Long continuous frame crossing several CC requests
    c0 = cc_runs;
    push_exp(OS_SCP, '0);
    for (int i = 0; i < 60; i++) begin
      d = $urandom;
      if (i == 59) send_beat(d, 4'hE, 1'b1, {d[31:8], 8'h9C});
      else         send_beat(d, 4'hF, 1'b0, d);
    end
    tvalid = 1'b0;
    drain("t5_drain");
    check_eq("t5_cc_runs", 32'(cc_runs - c0 >= 2), 32'd1);

    // Abort mid-frame by dropping channel_up
    channel_up = 1'b0;
    step(2);
    channel_up = 1'b1;
    push_exp(OS_SCP, '0);
    send_beat(32'hA1A1A1A1, 4'hF, 1'b0, 32'hA1A1A1A1);
    send_beat(32'hA2A2A2A2, 4'hF, 1'b0, 32'hA2A2A2A2);
    channel_up = 1'b0;
    tdata      = 32'hA3A3A3A3;
    e0         = ecp_cnt;
    step(1);
    @(negedge clk);
    check_eq("t6_abort_os", 32'(ordered_sets), 32'(OS_I));
    check_eq("t6_abort_tready", 32'(tready), 32'd0);
    step(3);
    check_eq("t6_no_ecp", 32'(ecp_cnt - e0), 32'd0);
    check_eq("t6_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef TX_FRAMER_STATS_EN
    check_eq("t6_abort_cnt", 32'(abort_cnt), 32'd1);
    check_eq("t6_frame_cnt", 32'(frame_cnt), 32'(frames_sent));
`endif

    // Three-cycle tvalid gap inside a frame
    tvalid = 1'b0;
    step(1);
    channel_up = 1'b1;
    max_gap    = 0;
    push_exp(OS_SCP, '0);
    send_beat(32'hB1B1B1B1, 4'hF, 1'b0, 32'hB1B1B1B1);
    send_beat(32'hB2B2B2B2, 4'hF, 1'b0, 32'hB2B2B2B2);
    tvalid = 1'b0;
    step(3);
    send_beat(32'hB3B3B3B3, 4'hF, 1'b0, 32'hB3B3B3B3);
    send_beat(32'hB4B4B4B4, 4'hF, 1'b1, 32'hB4B4B4B4);
    tvalid = 1'b0;
    drain("t7_drain");
    check_eq("t7_gap_len", 32'(max_gap), 32'd3);

    step(5);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
